// File: rtl/cpu_sampler_pkg.sv
// Shared types and constants for the CPU stream sampler.
// Used by cpu_sampler_fifo and cpu_stream_sampler.
package cpu_sampler_pkg;

  localparam int          DATA_W   = 32;
  localparam logic [15:0] DROP_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  function automatic logic [15:0] sat_inc(
    input logic [15:0] v
  );
    return (v == DROP_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/cpu_sampler_fifo.sv
// Show-ahead synchronous FIFO, DEPTH x DATA_W, with a
// registered head word and occupancy output.
module cpu_sampler_fifo
  import cpu_sampler_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_full,
  output logic              o_empty,
  output logic [AW:0]       o_level
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_head;
  logic [AW-1:0]     r_wr;
  logic [AW-1:0]     r_rd;
  logic [AW-1:0]     w_rd_nxt;
  logic [AW:0]       r_cnt;
  logic [AW:0]       w_cnt_nxt;
  logic              w_push;
  logic              w_pop;
  logic              w_bypass;

  assign o_full    = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty   = (r_cnt == '0);
  assign o_level   = r_cnt;
  assign o_rdata   = r_head;

  assign w_push    = i_push & ~o_full;
  assign w_pop     = i_pop & ~o_empty;
  assign w_rd_nxt  = r_rd + AW'(w_pop);
  assign w_cnt_nxt = r_cnt + (AW+1)'(w_push)
                   - (AW+1)'(w_pop);

  // New head is the word being written when
  // the queue is otherwise empty after the pop.
  assign w_bypass  = w_push && (w_rd_nxt == r_wr);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr] <= i_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_cnt  <= '0;
      r_head <= '0;
    end else begin
      if (w_push) begin
        r_wr <= r_wr + AW'(1);
      end
      r_rd  <= w_rd_nxt;
      r_cnt <= w_cnt_nxt;
      if (w_cnt_nxt != '0) begin
        r_head <= w_bypass ? i_wdata
                           : r_mem[w_rd_nxt];
      end
    end
  end

endmodule

// File: rtl/cpu_stream_sampler.sv
// Decimating sampler of the CPU data word into a stream FIFO.
// Define SAMPLER_DROP_CNT_EN to add the drop_count output.
module cpu_stream_sampler
  import cpu_sampler_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int DECIM    = 1,
  parameter int ERR_HOLD = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   clear,
  input  logic [DATA_W-1:0]      data_in,
  input  logic                   err_in,
  output logic [DATA_W-1:0]      m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   overflow,
  output logic                   err_seen,
  output logic [1:0]             state,
`ifdef SAMPLER_DROP_CNT_EN
  output logic [15:0]            drop_count,
`endif
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [DW-1:0] r_dec;
  logic [7:0]    r_hold;
  logic          r_ovf;
  logic          r_err;
  logic          w_dec_hit;
  logic          w_hold_done;
  logic          w_capture;
  logic          w_drop;
  logic          w_err_set;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;

  assign w_dec_hit   = (r_dec == DW'(DECIM - 1));
  assign w_hold_done = (r_state == ST_ERR) && !err_in
                    && (r_hold == 8'(ERR_HOLD - 1));
  assign w_capture   = (r_state == ST_RUN) && enable
                    && !err_in && w_dec_hit;
  assign w_drop      = w_capture & w_full;
  assign w_err_set   = (r_state == ST_RUN) && err_in;
  assign w_pop       = ~w_empty & m_ready;

  assign m_valid  = ~w_empty;
  assign overflow = r_ovf;
  assign err_seen = r_err;
  assign state    = r_state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Encoding 3 falls into the default arm and
  // behaves as idle.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_RUN: begin
        if (err_in) begin
          w_state_nxt = ST_ERR;
        end else if (!enable) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ERR: begin
        if (w_hold_done) begin
          w_state_nxt = enable ? ST_RUN : ST_IDLE;
        end
      end
      default: begin
        if (enable) begin
          w_state_nxt = err_in ? ST_ERR : ST_RUN;
        end
      end
    endcase
  end

  // Held at zero outside RUN so each entry
  // starts a fresh decimation period.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dec <= '0;
    end else if (r_state != ST_RUN) begin
      r_dec <= '0;
    end else if (w_dec_hit) begin
      r_dec <= '0;
    end else begin
      r_dec <= r_dec + DW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hold <= '0;
    end else if (r_state != ST_ERR) begin
      r_hold <= '0;
    end else if (err_in || w_hold_done) begin
      r_hold <= '0;
    end else begin
      r_hold <= r_hold + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ovf <= 1'b0;
      r_err <= 1'b0;
    end else begin
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (clear) begin
        r_ovf <= 1'b0;
      end
      if (w_err_set) begin
        r_err <= 1'b1;
      end else if (clear) begin
        r_err <= 1'b0;
      end
    end
  end

`ifdef SAMPLER_DROP_CNT_EN
  logic [15:0] r_drop;
  logic [15:0] w_drop_base;

  // A drop coinciding with clear counts as
  // the first drop after the clear.
  assign w_drop_base = clear ? 16'd0 : r_drop;
  assign drop_count  = r_drop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_drop <= '0;
    end else if (w_drop) begin
      r_drop <= sat_inc(w_drop_base);
    end else begin
      r_drop <= w_drop_base;
    end
  end
`endif

  cpu_sampler_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .i_push  (w_capture),
    .i_wdata (data_in),
    .i_pop   (w_pop),
    .o_rdata (m_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (fifo_level)
  );

endmodule

// File: tb/tb_cpu_stream_sampler.sv
// Bench for cpu_stream_sampler: DECIM=1 and DECIM=4 instances
// on shared inputs, checked against a queue-based model.
module tb_cpu_stream_sampler;

  logic        clk     = 1'b0;
  logic        reset_n = 1'b1;
  logic        enable  = 1'b0;
  logic        clear   = 1'b0;
  logic        err_in  = 1'b0;
  logic        m_ready = 1'b0;
  logic [31:0] data_in = '0;

  logic [31:0] o_data  [2];
  logic        o_valid [2];
  logic [4:0]  o_lvl   [2];
  logic [1:0]  o_st    [2];
  logic        o_ovf   [2];
  logic        o_err   [2];
`ifdef SAMPLER_DROP_CNT_EN
  logic [15:0] o_drop  [2];
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cpu_stream_sampler #(
    .DEPTH(16), .DECIM(1), .ERR_HOLD(4)
  ) u_d1 (
    .clk(clk), .reset_n(reset_n),
    .enable(enable), .clear(clear),
    .data_in(data_in), .err_in(err_in),
    .m_data(o_data[0]), .m_valid(o_valid[0]),
    .m_ready(m_ready), .overflow(o_ovf[0]),
    .err_seen(o_err[0]), .state(o_st[0]),
`ifdef SAMPLER_DROP_CNT_EN
    .drop_count(o_drop[0]),
`endif
    .fifo_level(o_lvl[0])
  );

  cpu_stream_sampler #(
    .DEPTH(16), .DECIM(4), .ERR_HOLD(4)
  ) u_d4 (
    .clk(clk), .reset_n(reset_n),
    .enable(enable), .clear(clear),
    .data_in(data_in), .err_in(err_in),
    .m_data(o_data[1]), .m_valid(o_valid[1]),
    .m_ready(m_ready), .overflow(o_ovf[1]),
    .err_seen(o_err[1]), .state(o_st[1]),
`ifdef SAMPLER_DROP_CNT_EN
    .drop_count(o_drop[1]),
`endif
    .fifo_level(o_lvl[1])
  );

  // Reference model: 0=idle 1=run 2=err
  int          e_st   [2];
  int          e_ph   [2];
  int          e_low  [2];
  bit          e_ovf  [2];
  bit          e_err  [2];
  int          e_drop [2];
  logic [31:0] e_last [2];
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [31:0] qhead(input int k);
    return (k == 0) ? q0[0] : q1[0];
  endfunction

  task automatic qpush(input int k, input logic [31:0] v);
    if (k == 0) q0.push_back(v);
    else q1.push_back(v);
  endtask

  task automatic qpop(input int k);
    if (k == 0) void'(q0.pop_front());
    else void'(q1.pop_front());
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    for (int k = 0; k < 2; k++) begin
      e_st[k] = 0; e_ph[k] = 0; e_low[k] = 0;
      e_ovf[k] = 0; e_err[k] = 0; e_drop[k] = 0;
      e_last[k] = '0;
    end
  endtask

  task automatic model_step(input int k);
    int  sz;
    int  nst;
    int  dec;
    bit  cap;
    bit  drop;
    dec  = (k == 0) ? 1 : 4;
    sz   = qsize(k);
    cap  = (e_st[k] == 1) && enable && !err_in
        && ((e_ph[k] % dec) == dec - 1);
    drop = cap && (sz == 16);
    if (sz > 0 && m_ready) qpop(k);
    if (cap && !drop) qpush(k, data_in);
    if (drop) e_ovf[k] = 1;
    else if (clear) e_ovf[k] = 0;
    if (e_st[k] == 1 && err_in) e_err[k] = 1;
    else if (clear) e_err[k] = 0;
    if (clear) e_drop[k] = 0;
    if (drop && e_drop[k] < 65535) e_drop[k]++;
    nst = e_st[k];
    case (e_st[k])
      1: begin
        if (err_in) nst = 2;
        else if (!enable) nst = 0;
      end
      2: begin
        if (err_in) e_low[k] = 0;
        else begin
          e_low[k]++;
          if (e_low[k] == 4) nst = enable ? 1 : 0;
        end
      end
      default: if (enable) nst = err_in ? 2 : 1;
    endcase
    if (nst != 2) e_low[k] = 0;
    e_ph[k] = (nst == 1 && e_st[k] == 1) ? e_ph[k] + 1 : 0;
    e_st[k] = nst;
    if (qsize(k) > 0) e_last[k] = qhead(k);
  endtask

  function automatic logic [57:0] obs(input int k);
    logic [15:0] d;
    d = '0;
`ifdef SAMPLER_DROP_CNT_EN
    d = o_drop[k];
`endif
    return {o_valid[k], o_data[k], o_lvl[k], o_st[k],
            o_ovf[k], o_err[k], d};
  endfunction

  function automatic logic [57:0] expv(input int k);
    logic [15:0] d;
    d = '0;
`ifdef SAMPLER_DROP_CNT_EN
    d = 16'(e_drop[k]);
`endif
    return {(qsize(k) > 0), e_last[k], 5'(qsize(k)),
            2'(e_st[k]), e_ovf[k], e_err[k], d};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (reset_n) begin
      model_step(0);
      model_step(1);
    end
    #1;
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (obs(k) !== 58'h0) begin
        n_bad++;
        $display("FAIL reset[%0d] got %h want 0", k, obs(k));
      end
    end
    @(negedge clk) reset_n = 1'b1;
  endtask

  task automatic test_stream();
    enable = 1'b1; m_ready = 1'b1;
    tick();
    for (int i = 0; i < 12; i++) begin
      data_in = 32'h10 + 32'(i);
      tick();
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (obs(k) !== expv(k)) begin
          n_bad++;
          $display("FAIL stream[%0d] cyc %0d got %h want %h",
                   k, i, obs(k), expv(k));
        end
      end
      n_cmp++;
      if (o_data[0] !== 32'h10 + 32'(i) || !o_valid[0]
          || o_lvl[0] > 5'd1) begin
        n_bad++;
        $display("FAIL stream_seq got %h/%0d lvl %0d want %h/1",
                 o_data[0], o_valid[0], o_lvl[0], 32'h10 + i);
      end
    end
  endtask

  task automatic test_decim();
    enable = 1'b0;
    repeat (3) tick();
    enable = 1'b1; data_in = 32'hFFFF_FFFF;
    tick();
    for (int i = 0; i < 16; i++) begin
      data_in = 32'(i);
      tick();
      n_cmp++;
      if (obs(1) !== expv(1)) begin
        n_bad++;
        $display("FAIL decim_model cyc %0d got %h want %h",
                 i, obs(1), expv(1));
      end
      n_cmp++;
      if ((i % 4) == 3) begin
        if (o_valid[1] !== 1'b1 || o_data[1] !== 32'(i)) begin
          n_bad++;
          $display("FAIL decim_hit cyc %0d got %h/%0d want %h/1",
                   i, o_data[1], o_valid[1], i);
        end
      end else if (o_valid[1] !== 1'b0) begin
        n_bad++;
        $display("FAIL decim_gap cyc %0d got valid %0d want 0",
                 i, o_valid[1]);
      end
    end
    enable = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_overflow();
    logic [31:0] got [$];
    m_ready = 1'b0; enable = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) begin
      data_in = 32'h100 + 32'(i);
      tick();
    end
    n_cmp++;
    if (o_lvl[0] !== 5'd16 || o_ovf[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL ovf_full got lvl %0d ovf %0d want 16 1",
               o_lvl[0], o_ovf[0]);
    end
`ifdef SAMPLER_DROP_CNT_EN
    n_cmp++;
    if (o_drop[0] !== 16'd4) begin
      n_bad++;
      $display("FAIL ovf_drops got %0d want 4", o_drop[0]);
    end
`endif
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (obs(k) !== expv(k)) begin
        n_bad++;
        $display("FAIL ovf_model[%0d] got %h want %h",
                 k, obs(k), expv(k));
      end
    end
    enable = 1'b0; m_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (o_valid[0]) got.push_back(o_data[0]);
      tick();
    end
    n_cmp++;
    if (got.size() != 16) begin
      n_bad++;
      $display("FAIL ovf_count got %0d want 16", got.size());
    end
    for (int i = 0; i < got.size() && i < 16; i++) begin
      n_cmp++;
      if (got[i] !== 32'h100 + 32'(i)) begin
        n_bad++;
        $display("FAIL ovf_order %0d got %h want %h",
                 i, got[i], 32'h100 + i);
      end
    end
  endtask

  task automatic test_err();
    enable = 1'b1; m_ready = 1'b1;
    repeat (4) begin
      data_in = $urandom;
      tick();
    end
    err_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (o_st[0] !== 2'd2 || o_err[0] !== 1'b1
          || o_lvl[0] !== 5'd0) begin
        n_bad++;
        $display("FAIL err_enter %0d got st %0d seen %0d lvl %0d want 2 1 0",
                 i, o_st[0], o_err[0], o_lvl[0]);
      end
    end
    err_in = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_cmp++;
      if (o_st[0] !== ((i == 4) ? 2'd1 : 2'd2)) begin
        n_bad++;
        $display("FAIL err_hold %0d got st %0d want %0d",
                 i, o_st[0], (i == 4) ? 1 : 2);
      end
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (obs(k) !== expv(k)) begin
          n_bad++;
          $display("FAIL err_model[%0d] got %h want %h",
                   k, obs(k), expv(k));
        end
      end
    end
  endtask

  task automatic test_clear();
    m_ready = 1'b0;
    repeat (5) tick();
    enable = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0;
    n_cmp++;
    if (o_ovf[0] !== 1'b0 || o_err[0] !== 1'b0
        || o_lvl[0] !== 5'd5) begin
      n_bad++;
      $display("FAIL clear_alone got ovf %0d seen %0d lvl %0d want 0 0 5",
               o_ovf[0], o_err[0], o_lvl[0]);
    end
    enable = 1'b1;
    repeat (12) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n_cmp++;
    if (o_ovf[0] !== 1'b1 || o_lvl[0] !== 5'd16) begin
      n_bad++;
      $display("FAIL clear_vs_drop got ovf %0d lvl %0d want 1 16",
               o_ovf[0], o_lvl[0]);
    end
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (obs(k) !== expv(k)) begin
        n_bad++;
        $display("FAIL clear_model[%0d] got %h want %h",
                 k, obs(k), expv(k));
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      enable  = ($urandom_range(7) != 0);
      err_in  = ($urandom_range(24) == 0);
      clear   = ($urandom_range(30) == 0);
      m_ready = (((i / 60) % 2) == 1)
              ? ($urandom_range(3) == 0)
              : ($urandom_range(1) == 1);
      data_in = $urandom;
      tick();
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (obs(k) !== expv(k)) begin
          n_bad++;
          $display("FAIL random[%0d] cyc %0d got %h want %h",
                   k, i, obs(k), expv(k));
        end
      end
    end
    err_in = 1'b0; clear = 1'b0;
  endtask

  task automatic test_reset_mid();
    enable = 1'b0; m_ready = 1'b1;
    repeat (30) tick();
    m_ready = 1'b0; enable = 1'b1;
    tick();
    repeat (7) begin
      data_in = $urandom;
      tick();
    end
    err_in = 1'b1;
    tick();
    err_in = 1'b0;
    n_cmp++;
    if (o_lvl[0] !== 5'd7 || o_err[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_setup got lvl %0d seen %0d want 7 1",
               o_lvl[0], o_err[0]);
    end
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (o_valid[k] !== 1'b0 || o_lvl[k] !== 5'd0
          || o_st[k] !== 2'd0 || o_ovf[k] !== 1'b0
          || o_err[k] !== 1'b0 || o_data[k] !== 32'd0) begin
        n_bad++;
        $display("FAIL mid_reset[%0d] got %h want 0", k, obs(k));
      end
    end
    enable = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    tick();
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (obs(k) !== expv(k)) begin
        n_bad++;
        $display("FAIL mid_after[%0d] got %h want %h",
                 k, obs(k), expv(k));
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_decim();
    test_overflow();
    test_err();
    test_clear();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
